// File: rtl/video_stream_framer.sv
// rtl/video_stream_framer.sv - frames a scaled pixel stream into lines (tlast) and frames (tuser)
// Counts pixels against latched geometry, repairs early/late input tlast and flags both.
module video_stream_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  enable,
    input  logic [CNT_WIDTH-1:0]  cfg_width,
    input  logic [CNT_WIDTH-1:0]  cfg_height,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_input,
    input  logic                  s_axis_tvalid_input,
    input  logic                  s_axis_tlast_input,
    output logic                  s_axis_tready_input,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_output,
    output logic                  m_axis_tvalid_output,
    output logic                  m_axis_tlast_output,
    output logic                  m_axis_tuser_output,
    input  logic                  m_axis_tready_output,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_early_last,
    output logic                  err_late_last,
    output logic                  err_cfg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  width_q;
    logic [CNT_WIDTH-1:0]  height_q;
    logic [CNT_WIDTH-1:0]  x_q;
    logic [CNT_WIDTH-1:0]  y_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  tuser_q;
    logic                  enable_q;
    logic                  frame_done_q;
    logic                  err_early_q;
    logic                  err_late_q;
    logic                  err_cfg_q;

    logic x_last;
    logic y_last;
    logic line_end;
    logic s_ready;
    logic accept;
    logic cfg_ok;

    assign x_last   = (x_q == width_q - CNT_ONE);
    assign y_last   = (y_q == height_q - CNT_ONE);
    assign line_end = x_last || s_axis_tlast_input;
    assign cfg_ok   = (cfg_width != '0) && (cfg_height != '0);
    // The output register may be refilled in the same cycle it drains.
    assign s_ready  = (state_q == ST_ACTIVE) && (!tvalid_q || m_axis_tready_output);
    assign accept   = s_ready && s_axis_tvalid_input;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= ST_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            enable_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_early_q  <= 1'b0;
            err_late_q   <= 1'b0;
            err_cfg_q    <= 1'b0;
        end else begin
            enable_q     <= enable;
            frame_done_q <= 1'b0;
            err_early_q  <= 1'b0;
            err_late_q   <= 1'b0;
            err_cfg_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        if (cfg_ok) begin
                            width_q  <= cfg_width;
                            height_q <= cfg_height;
                            x_q      <= '0;
                            y_q      <= '0;
                            state_q  <= ST_ACTIVE;
                        end else if (!enable_q) begin
                            err_cfg_q <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (accept) begin
                        tdata_q     <= s_axis_tdata_input;
                        tvalid_q    <= 1'b1;
                        tuser_q     <= (x_q == '0) && (y_q == '0);
                        tlast_q     <= line_end;
                        err_early_q <= s_axis_tlast_input && !x_last;
                        err_late_q  <= x_last && !s_axis_tlast_input;
                        if (line_end) begin
                            x_q <= '0;
                            if (y_last) begin
                                state_q <= ST_FLUSH;
                            end else begin
                                y_q <= y_q + CNT_ONE;
                            end
                        end else begin
                            x_q <= x_q + CNT_ONE;
                        end
                    end else if (m_axis_tready_output) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tuser_q  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (tvalid_q && m_axis_tready_output) begin
                        tvalid_q     <= 1'b0;
                        tlast_q      <= 1'b0;
                        tuser_q      <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready_input  = s_ready;
    assign m_axis_tdata_output  = tdata_q;
    assign m_axis_tvalid_output = tvalid_q;
    assign m_axis_tlast_output  = tlast_q;
    assign m_axis_tuser_output  = tuser_q;
    assign busy                 = (state_q != ST_IDLE);
    assign frame_done           = frame_done_q;
    assign err_early_last       = err_early_q;
    assign err_late_last        = err_late_q;
    assign err_cfg              = err_cfg_q;

endmodule

// File: tb/tb_video_stream_framer.sv
// tb/tb_video_stream_framer.sv - directed self-checking bench for video_stream_framer
module tb_video_stream_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] cfg_width = 16'd0;
    logic [15:0] cfg_height = 16'd0;
    logic [31:0] s_data = 32'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_user;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        err_early;
    logic        err_late;
    logic        err_cfg;

    int errors = 0;
    int checks = 0;

    logic [31:0] src_data [32];
    bit          src_tlast [32];
    int          n_src;

    logic [31:0] out_data [32];
    bit          out_last [32];
    bit          out_user [32];
    int          out_cyc [32];
    int          acc_cyc [32];
    int          early_cyc [4];
    int          late_cyc [4];
    int          n_out, n_acc, n_early, n_late, n_done, done_cyc, stall_viol;

    video_stream_framer #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .axi_aclk             (clk),
        .axi_aresetn          (rst_n),
        .enable               (enable),
        .cfg_width            (cfg_width),
        .cfg_height           (cfg_height),
        .s_axis_tdata_input   (s_data),
        .s_axis_tvalid_input  (s_valid),
        .s_axis_tlast_input   (s_last),
        .s_axis_tready_input  (s_ready),
        .m_axis_tdata_output  (m_data),
        .m_axis_tvalid_output (m_valid),
        .m_axis_tlast_output  (m_last),
        .m_axis_tuser_output  (m_user),
        .m_axis_tready_output (m_ready),
        .busy                 (busy),
        .frame_done           (frame_done),
        .err_early_last       (err_early),
        .err_late_last        (err_late),
        .err_cfg              (err_cfg)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // mode 0: tlast on every line end, 1: never tlast, 2: tlast on 3rd pixel of line 0 (4x2 only)
    task automatic set_src(input int w, input int h, input int mode);
        for (int k = 0; k < 32; k++) begin
            src_data[k]  = 32'hC0DE_0000 | 32'(k * 7 + 3);
            src_tlast[k] = 1'b0;
        end
        if (mode == 2) begin
            n_src = 7;
            src_tlast[2] = 1'b1;
            src_tlast[6] = 1'b1;
        end else begin
            n_src = w * h;
            for (int k = 0; k < n_src; k++)
                src_tlast[k] = (mode == 0) && ((k % w) == w - 1);
        end
    endtask

    task automatic run_frame(input int w, input int h, input int pattern, input bit keep_en,
                             input int stop_acc, input int max_cycles);
        int          src_idx;
        bit          held_v;
        logic [31:0] held_d;
        src_idx = 0; held_v = 1'b0; held_d = '0;
        n_out = 0; n_acc = 0; n_early = 0; n_late = 0; n_done = 0; done_cyc = -1; stall_viol = 0;
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        enable     = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            @(posedge clk); #1;
            m_ready = (pattern == 0) || (c % 2 == 0);
            if (src_idx < n_src) begin
                s_valid = 1'b1; s_data = src_data[src_idx]; s_last = src_tlast[src_idx];
            end else begin
                s_valid = 1'b0; s_data = '0; s_last = 1'b0;
            end
            if (busy && !keep_en) enable = 1'b0;
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (n_acc < 32) acc_cyc[n_acc] = c;
                n_acc++; src_idx++;
            end
            if (held_v && (!m_valid || m_data !== held_d)) stall_viol++;
            held_v = m_valid && !m_ready;
            held_d = m_data;
            if (m_valid && m_ready && n_out < 32) begin
                out_data[n_out] = m_data; out_last[n_out] = m_last;
                out_user[n_out] = m_user; out_cyc[n_out] = c;
                n_out++;
            end
            if (err_early) begin if (n_early < 4) early_cyc[n_early] = c; n_early++; end
            if (err_late)  begin if (n_late < 4)  late_cyc[n_late]   = c; n_late++;  end
            if (frame_done) begin n_done++; done_cyc = c; end
            if (stop_acc != 0 && n_acc >= stop_acc) break;
            if (n_done != 0) break;
        end
        if (stop_acc == 0) begin
            s_valid = 1'b0; s_last = 1'b0;
            checks++;
            if (n_done !== 1) begin
                errors++;
                $display("FAIL frame_done_seen: got %0d pulses, expected 1 within %0d cycles", n_done, max_cycles);
            end
        end
    endtask

    function automatic logic [31:0] last_mask();
        logic [31:0] m = '0;
        for (int k = 0; k < n_out; k++) m[k] = out_last[k];
        return m;
    endfunction

    function automatic logic [31:0] user_mask();
        logic [31:0] m = '0;
        for (int k = 0; k < n_out; k++) m[k] = out_user[k];
        return m;
    endfunction

    function automatic int data_bad();
        int bad = 0;
        for (int k = 0; k < n_out; k++) if (out_data[k] !== src_data[k]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_last, m_user, busy, frame_done, err_early, err_late, err_cfg} !== 9'd0 || m_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b data=%h, expected all zero",
                     {s_ready, m_valid, m_last, m_user, busy, frame_done, err_early, err_late, err_cfg}, m_data);
        end
        rst_n = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: s_ready=%b busy=%b, expected 0 0", s_ready, busy);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_basic();
        set_src(4, 2, 0);
        run_frame(4, 2, 0, 1'b0, 0, 60);
        checks++;
        if (n_out !== 8) begin errors++; $display("FAIL basic_beats: got %0d, expected 8", n_out); end
        checks++;
        if (data_bad() !== 0) begin errors++; $display("FAIL basic_data: %0d wrong beats, expected 0", data_bad()); end
        checks++;
        if (last_mask() !== 32'h88) begin errors++; $display("FAIL basic_tlast: mask %h, expected 88", last_mask()); end
        checks++;
        if (user_mask() !== 32'h01) begin errors++; $display("FAIL basic_tuser: mask %h, expected 01", user_mask()); end
        checks++;
        if (out_cyc[0] !== acc_cyc[0] + 1) begin
            errors++; $display("FAIL basic_latency: out cycle %0d, expected %0d", out_cyc[0], acc_cyc[0] + 1);
        end
        checks++;
        if (done_cyc !== out_cyc[7] + 1) begin
            errors++; $display("FAIL basic_done_time: cycle %0d, expected %0d", done_cyc, out_cyc[7] + 1);
        end
        checks++;
        if (n_early !== 0 || n_late !== 0) begin
            errors++; $display("FAIL basic_no_err: early=%0d late=%0d, expected 0 0", n_early, n_late);
        end
    endtask

    task automatic test_stall();
        set_src(4, 2, 0);
        run_frame(4, 2, 1, 1'b0, 0, 80);
        checks++;
        if (n_out !== 8 || data_bad() !== 0) begin
            errors++; $display("FAIL stall_seq: beats=%0d bad=%0d, expected 8 0", n_out, data_bad());
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold: %0d changes while stalled, expected 0", stall_viol); end
        checks++;
        if (last_mask() !== 32'h88 || user_mask() !== 32'h01) begin
            errors++; $display("FAIL stall_flags: last=%h user=%h, expected 88 01", last_mask(), user_mask());
        end
    endtask

    task automatic test_early_last();
        set_src(4, 2, 2);
        run_frame(4, 2, 0, 1'b0, 0, 60);
        checks++;
        if (n_out !== 7 || data_bad() !== 0) begin
            errors++; $display("FAIL early_beats: beats=%0d bad=%0d, expected 7 0", n_out, data_bad());
        end
        checks++;
        if (last_mask() !== 32'h44 || user_mask() !== 32'h01) begin
            errors++; $display("FAIL early_flags: last=%h user=%h, expected 44 01", last_mask(), user_mask());
        end
        checks++;
        if (n_early !== 1 || n_late !== 0) begin
            errors++; $display("FAIL early_count: early=%0d late=%0d, expected 1 0", n_early, n_late);
        end
        checks++;
        if (early_cyc[0] !== acc_cyc[2] + 1) begin
            errors++; $display("FAIL early_time: cycle %0d, expected %0d", early_cyc[0], acc_cyc[2] + 1);
        end
    endtask

    task automatic test_late_last();
        set_src(4, 2, 1);
        run_frame(4, 2, 0, 1'b0, 0, 60);
        checks++;
        if (n_out !== 8 || last_mask() !== 32'h88) begin
            errors++; $display("FAIL late_beats: beats=%0d last=%h, expected 8 88", n_out, last_mask());
        end
        checks++;
        if (n_late !== 2 || n_early !== 0) begin
            errors++; $display("FAIL late_count: late=%0d early=%0d, expected 2 0", n_late, n_early);
        end
        checks++;
        if (late_cyc[0] !== acc_cyc[3] + 1 || late_cyc[1] !== acc_cyc[7] + 1) begin
            errors++; $display("FAIL late_time: cycles %0d %0d, expected %0d %0d",
                               late_cyc[0], late_cyc[1], acc_cyc[3] + 1, acc_cyc[7] + 1);
        end
    endtask

    task automatic test_cfg_error();
        int pulses = 0;
        int bad = 0;
        cfg_width = 16'd0; cfg_height = 16'd2; s_valid = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (err_cfg) pulses++;
            if (busy || s_ready) bad++;
        end
        enable = 1'b0;
        cfg_width = 16'd4; cfg_height = 16'd0;
        @(negedge clk);
        enable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (err_cfg) pulses++;
            if (busy || s_ready) bad++;
        end
        enable = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pulses !== 2) begin errors++; $display("FAIL cfg_pulses: got %0d, expected 2 (one per rising edge)", pulses); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL cfg_idle: %0d cycles busy or ready, expected 0", bad); end
    endtask

    task automatic test_width_one();
        set_src(1, 1, 0);
        run_frame(1, 1, 0, 1'b0, 0, 30);
        checks++;
        if (n_out !== 1 || out_user[0] !== 1'b1 || out_last[0] !== 1'b1) begin
            errors++; $display("FAIL w1h1: beats=%0d user=%b last=%b, expected 1 1 1", n_out, out_user[0], out_last[0]);
        end
        set_src(1, 3, 0);
        run_frame(1, 3, 0, 1'b0, 0, 30);
        checks++;
        if (n_out !== 3 || last_mask() !== 32'h7 || user_mask() !== 32'h1 || n_early !== 0 || n_late !== 0) begin
            errors++; $display("FAIL w1h3: beats=%0d last=%h user=%h early=%0d late=%0d, expected 3 7 1 0 0",
                               n_out, last_mask(), user_mask(), n_early, n_late);
        end
    endtask

    task automatic test_back_to_back();
        set_src(4, 2, 0);
        run_frame(4, 2, 0, 1'b1, 0, 60);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_idle: busy=%b, expected 0", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_rearm: busy=%b, expected 1", busy); end
        run_frame(4, 2, 0, 1'b0, 0, 60);
        checks++;
        if (n_out !== 8 || user_mask() !== 32'h01 || data_bad() !== 0) begin
            errors++; $display("FAIL b2b_second: beats=%0d user=%h bad=%0d, expected 8 01 0", n_out, user_mask(), data_bad());
        end
    endtask

    task automatic test_reset_mid_frame();
        set_src(4, 2, 0);
        run_frame(4, 2, 0, 1'b0, 5, 60);
        @(posedge clk); #2;
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== src_data[4]) begin
            errors++; $display("FAIL mid_held: valid=%b data=%h, expected 1 %h", m_valid, m_data, src_data[4]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_last, m_user, busy, frame_done, err_early, err_late, err_cfg} !== 9'd0 || m_data !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_async: flags=%b data=%h, expected all zero",
                     {s_ready, m_valid, m_last, m_user, busy, frame_done, err_early, err_late, err_cfg}, m_data);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL mid_wait_idle: busy=%b s_ready=%b, expected 0 0", busy, s_ready);
        end
        s_valid = 1'b0;
        run_frame(4, 2, 0, 1'b0, 0, 60);
        checks++;
        if (n_out !== 8 || out_user[0] !== 1'b1 || user_mask() !== 32'h01 || data_bad() !== 0) begin
            errors++; $display("FAIL mid_restart: beats=%0d user=%h bad=%0d, expected 8 01 0", n_out, user_mask(), data_bad());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_early_last();
        test_late_last();
        test_cfg_error();
        test_width_one();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
